// File: rtl/varlat_inorder_pkg.sv
// rtl/varlat_inorder_pkg.sv - shared types and bank decode for varlat_inorder_router
package varlat_inorder_pkg;

    localparam int unsigned BankIdxWidth = 8;
    localparam int unsigned AddrMaxWidth = 64;

    typedef logic [BankIdxWidth-1:0] bank_idx_t;

    typedef struct packed {
        bank_idx_t bank;
        logic      we;
    } ini_fifo_entry_t;

    function automatic bank_idx_t bank_sel(input logic [AddrMaxWidth-1:0] addr,
                                           input int unsigned byte_off,
                                           input int unsigned bank_w);
        logic [AddrMaxWidth-1:0] sh;
        sh = (addr >> byte_off) & ((AddrMaxWidth'(1) << bank_w) - AddrMaxWidth'(1));
        return bank_idx_t'(sh);
    endfunction

endpackage

// File: rtl/varlat_sync_fifo.sv
// rtl/varlat_sync_fifo.sv - registered-output synchronous FIFO, push accepted when full only with a pop
module varlat_sync_fifo #(
    parameter int unsigned Depth = 4,
    parameter type         T     = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    T                mem [Depth];
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic [CntW-1:0] count;
    logic            do_push, do_pop;

    assign full_o  = (count == CntW'(Depth));
    assign empty_o = (count == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/varlat_inorder_router.sv
// rtl/varlat_inorder_router.sv - NumIn x NumOut in-order router to variable-latency banks
// Optional VARLAT_INORDER_RSP_CUT_EN registers vld_o/rdata_o.
module varlat_inorder_router
    import varlat_inorder_pkg::*;
#(
    parameter int unsigned NumIn           = 4,
    parameter int unsigned NumOut          = 8,
    parameter int unsigned AddrWidth       = 32,
    parameter int unsigned DataWidth       = 32,
    parameter int unsigned BeWidth         = DataWidth / 8,
    parameter int unsigned AddrMemWidth    = 12,
    parameter int unsigned ByteOffWidth    = $clog2(DataWidth) - 3,
    parameter int unsigned IniOutstanding  = 4,
    parameter int unsigned BankOutstanding = 4,
    parameter bit          WriteRespOn     = 1'b1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumIn-1:0]                     req_i,
    input  logic [NumIn-1:0][AddrWidth-1:0]      add_i,
    input  logic [NumIn-1:0]                     we_i,
    input  logic [NumIn-1:0][DataWidth-1:0]      wdata_i,
    input  logic [NumIn-1:0][BeWidth-1:0]        be_i,
    output logic [NumIn-1:0]                     gnt_o,
    output logic [NumIn-1:0]                     vld_o,
    output logic [NumIn-1:0][DataWidth-1:0]      rdata_o,
    output logic [NumOut-1:0]                    req_o,
    input  logic [NumOut-1:0]                    gnt_i,
    output logic [NumOut-1:0][AddrMemWidth-1:0]  add_o,
    output logic [NumOut-1:0]                    we_o,
    output logic [NumOut-1:0][DataWidth-1:0]     wdata_o,
    output logic [NumOut-1:0][BeWidth-1:0]       be_o,
    input  logic [NumOut-1:0]                    rvalid_i,
    output logic [NumOut-1:0]                    rready_o,
    input  logic [NumOut-1:0][DataWidth-1:0]     rdata_i
);
    localparam int unsigned BankW = $clog2(NumOut);
    localparam int unsigned IniW  = (NumIn > 1) ? $clog2(NumIn) : 1;
    typedef logic [IniW-1:0] ini_idx_t;

    bank_idx_t       ini_bank [NumIn];
    ini_fifo_entry_t ihead    [NumIn];
    logic [NumIn-1:0] ifull, iempty, eligible, ipop, vld_c;
    logic [NumIn-1:0][DataWidth-1:0] rdata_c;

    logic [NumOut-1:0] bfull, bempty, bpush, rsp_pop;
    ini_idx_t bhead [NumOut];
    ini_idx_t win   [NumOut];
    ini_idx_t rr_ptr[NumOut];

    logic unused_addr;
    assign unused_addr = ^add_i;

    always_comb begin
        for (int i = 0; i < NumIn; i++) begin
            ini_bank[i] = bank_sel(AddrMaxWidth'(add_i[i]), ByteOffWidth, BankW);
            eligible[i] = req_i[i] & ~ifull[i] & ~rst_i;
        end
    end

    // Round-robin search starts at each bank's pointer; payload always follows the winner.
    always_comb begin
        logic found;
        int   idx;
        gnt_o = '0;
        for (int k = 0; k < NumOut; k++) begin
            found  = 1'b0;
            win[k] = '0;
            for (int o = 0; o < NumIn; o++) begin
                idx = (int'(rr_ptr[k]) + o) % NumIn;
                if (!found && eligible[idx] && ini_bank[idx] == bank_idx_t'(k)) begin
                    found  = 1'b1;
                    win[k] = ini_idx_t'(idx);
                end
            end
            req_o[k]   = found & ~bfull[k];
            bpush[k]   = req_o[k] & gnt_i[k];
            add_o[k]   = add_i[win[k]][ByteOffWidth + BankW +: AddrMemWidth];
            we_o[k]    = we_i[win[k]];
            wdata_o[k] = wdata_i[win[k]];
            be_o[k]    = be_i[win[k]];
            if (bpush[k]) gnt_o[win[k]] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NumOut; k++) rr_ptr[k] <= '0;
        end else begin
            for (int k = 0; k < NumOut; k++) begin
                if (bpush[k]) rr_ptr[k] <= (int'(win[k]) == NumIn - 1) ? '0 : win[k] + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NumIn; i++) begin : g_ififo
        varlat_sync_fifo #(.Depth(IniOutstanding), .T(ini_fifo_entry_t)) u_ififo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (gnt_o[i]),
            .data_i  (ini_fifo_entry_t'({ini_bank[i], we_i[i]})),
            .pop_i   (ipop[i]),
            .data_o  (ihead[i]),
            .full_o  (ifull[i]),
            .empty_o (iempty[i])
        );
    end

    for (genvar k = 0; k < NumOut; k++) begin : g_bfifo
        varlat_sync_fifo #(.Depth(BankOutstanding), .T(ini_idx_t)) u_bfifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (bpush[k]),
            .data_i  (win[k]),
            .pop_i   (rsp_pop[k]),
            .data_o  (bhead[k]),
            .full_o  (bfull[k]),
            .empty_o (bempty[k])
        );
    end

    // A bank may only retire when its oldest transaction is also its initiator's oldest.
    always_comb begin
        ipop    = '0;
        vld_c   = '0;
        rdata_c = '0;
        for (int k = 0; k < NumOut; k++) begin
            rready_o[k] = ~bempty[k] & ~iempty[bhead[k]] &
                          (ihead[bhead[k]].bank == bank_idx_t'(k));
            rsp_pop[k]  = rready_o[k] & rvalid_i[k];
            if (rsp_pop[k]) begin
                ipop[bhead[k]]    = 1'b1;
                vld_c[bhead[k]]   = ~ihead[bhead[k]].we | WriteRespOn;
                rdata_c[bhead[k]] = rdata_i[k];
            end
        end
    end

`ifdef VARLAT_INORDER_RSP_CUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) vld_o <= '0;
        else       vld_o <= vld_c;
        rdata_o <= rdata_c;
    end
`else
    assign vld_o   = vld_c;
    assign rdata_o = rdata_c;
`endif

endmodule

// File: tb/tb_varlat_inorder_router.sv
// tb/tb_varlat_inorder_router.sv - directed self-checking bench for varlat_inorder_router
module tb_varlat_inorder_router;
    localparam int NI = 4, NO = 8, AW = 32, DW = 32, BW = 4, MW = 12;

    logic clk = 1'b0;
    logic rst;
    logic [NI-1:0] req, we, gnt_o, vld_o, nw_gnt_o, nw_vld_o;
    logic [NI-1:0][AW-1:0] add;
    logic [NI-1:0][DW-1:0] wdata, rdata_o, nw_rdata_o;
    logic [NI-1:0][BW-1:0] be;
    logic [NO-1:0] req_o, gnt_i, we_o, rvalid_i, rready_o;
    logic [NO-1:0] nw_req_o, nw_we_o, nw_rready_o;
    logic [NO-1:0][MW-1:0] add_o, nw_add_o;
    logic [NO-1:0][DW-1:0] wdata_o, rdata_i, nw_wdata_o;
    logic [NO-1:0][BW-1:0] be_o, nw_be_o;
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    varlat_inorder_router u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .we_i(we), .wdata_i(wdata),
        .be_i(be), .gnt_o(gnt_o), .vld_o(vld_o), .rdata_o(rdata_o), .req_o(req_o),
        .gnt_i(gnt_i), .add_o(add_o), .we_o(we_o), .wdata_o(wdata_o), .be_o(be_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i)
    );

    varlat_inorder_router #(.WriteRespOn(1'b0)) u_dut_nw (
        .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .we_i(we), .wdata_i(wdata),
        .be_i(be), .gnt_o(nw_gnt_o), .vld_o(nw_vld_o), .rdata_o(nw_rdata_o), .req_o(nw_req_o),
        .gnt_i(gnt_i), .add_o(nw_add_o), .we_o(nw_we_o), .wdata_o(nw_wdata_o), .be_o(nw_be_o),
        .rvalid_i(rvalid_i), .rready_o(nw_rready_o), .rdata_i(rdata_i)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear;
        req = '0; we = '0; add = '0; wdata = '0; be = '0;
        gnt_i = '0; rvalid_i = '0; rdata_i = '0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_tests += 4;
        if (req_o !== 8'h00)   begin n_fail++; $display("FAIL reset_req_o got %h want 00", req_o); end
        if (gnt_o !== 4'h0)    begin n_fail++; $display("FAIL reset_gnt_o got %h want 0", gnt_o); end
        if (vld_o !== 4'h0)    begin n_fail++; $display("FAIL reset_vld_o got %h want 0", vld_o); end
        if (rready_o !== 8'h0) begin n_fail++; $display("FAIL reset_rready got %h want 00", rready_o); end
        tick();
    endtask

    task automatic test_single_read;
        req[0] = 1'b1; add[0] = 32'h0000_0014; gnt_i = 8'h20;
        @(negedge clk);
        n_tests += 3;
        if (gnt_o !== 4'b0001)   begin n_fail++; $display("FAIL single_gnt got %b want 0001", gnt_o); end
        if (req_o !== 8'h20)     begin n_fail++; $display("FAIL single_req_o got %h want 20", req_o); end
        if (add_o[5] !== 12'h0)  begin n_fail++; $display("FAIL single_add_o got %h want 000", add_o[5]); end
        tick();
        clear();
        @(negedge clk);
        n_tests += 2;
        if (rready_o !== 8'h20) begin n_fail++; $display("FAIL single_rready got %h want 20", rready_o); end
        if (vld_o !== 4'h0)     begin n_fail++; $display("FAIL single_early_vld got %h want 0", vld_o); end
        tick(); tick();
        rvalid_i[5] = 1'b1; rdata_i[5] = 32'hCAFE_0005;
        @(negedge clk);
        n_tests += 2;
        if (vld_o !== 4'b0001)            begin n_fail++; $display("FAIL single_vld got %b want 0001", vld_o); end
        if (rdata_o[0] !== 32'hCAFE_0005) begin n_fail++; $display("FAIL single_rdata got %h want cafe0005", rdata_o[0]); end
        tick();
        clear();
        @(negedge clk);
        n_tests++;
        if (rready_o !== 8'h00) begin n_fail++; $display("FAIL single_drained got %h want 00", rready_o); end
        tick();
    endtask

    task automatic test_contention;
        for (int i = 0; i < NI; i++) add[i] = ((i + 1) << 5) | 32'h8;
        for (int c = 0; c < 6; c++) begin
            req = (c < 5) ? 4'hF : 4'h0;
            gnt_i = 8'h04;
            rvalid_i[2] = (c >= 1);
            rdata_i[2] = 32'hD000_0000 + c - 1;
            @(negedge clk);
            if (c < 5) begin
                n_tests += 2;
                if (gnt_o !== 4'(1 << (c % 4)))
                    begin n_fail++; $display("FAIL contention_gnt c=%0d got %b want %b", c, gnt_o, 4'(1 << (c % 4))); end
                if (add_o[2] !== 12'((c % 4) + 1))
                    begin n_fail++; $display("FAIL contention_add c=%0d got %h want %h", c, add_o[2], (c % 4) + 1); end
            end
            if (c >= 1) begin
                n_tests += 2;
                if (vld_o !== 4'(1 << ((c - 1) % 4)))
                    begin n_fail++; $display("FAIL contention_vld c=%0d got %b", c, vld_o); end
                if (rdata_o[(c - 1) % 4] !== 32'hD000_0000 + c - 1)
                    begin n_fail++; $display("FAIL contention_rdata c=%0d got %h want %h", c, rdata_o[(c - 1) % 4], 32'hD000_0000 + c - 1); end
            end
            tick();
        end
        clear();
    endtask

    task automatic test_out_of_order;
        req[1] = 1'b1; add[1] = 32'h0000_0060; gnt_i = 8'h01;
        @(negedge clk);
        n_tests += 2;
        if (gnt_o !== 4'b0010)  begin n_fail++; $display("FAIL ooo_gnt0 got %b want 0010", gnt_o); end
        if (add_o[0] !== 12'h3) begin n_fail++; $display("FAIL ooo_add0 got %h want 003", add_o[0]); end
        tick();
        add[1] = 32'h0000_0004; gnt_i = 8'h02;
        @(negedge clk);
        n_tests++;
        if (gnt_o !== 4'b0010) begin n_fail++; $display("FAIL ooo_gnt1 got %b want 0010", gnt_o); end
        tick();
        for (int c = 2; c < 6; c++) begin
            req = '0; gnt_i = '0; rvalid_i[1] = 1'b1; rdata_i[1] = 32'hBBBB_0001;
            @(negedge clk);
            n_tests += 2;
            if (rready_o !== 8'h01) begin n_fail++; $display("FAIL ooo_hold c=%0d got %h want 01", c, rready_o); end
            if (vld_o !== 4'h0)     begin n_fail++; $display("FAIL ooo_novld c=%0d got %b want 0000", c, vld_o); end
            tick();
        end
        rvalid_i[0] = 1'b1; rdata_i[0] = 32'hAAAA_0000;
        @(negedge clk);
        n_tests += 2;
        if (vld_o !== 4'b0010)            begin n_fail++; $display("FAIL ooo_vld_b0 got %b want 0010", vld_o); end
        if (rdata_o[1] !== 32'hAAAA_0000) begin n_fail++; $display("FAIL ooo_rdata_b0 got %h want aaaa0000", rdata_o[1]); end
        tick();
        rvalid_i[0] = 1'b0;
        @(negedge clk);
        n_tests += 3;
        if (rready_o !== 8'h02)           begin n_fail++; $display("FAIL ooo_rready_b1 got %h want 02", rready_o); end
        if (vld_o !== 4'b0010)            begin n_fail++; $display("FAIL ooo_vld_b1 got %b want 0010", vld_o); end
        if (rdata_o[1] !== 32'hBBBB_0001) begin n_fail++; $display("FAIL ooo_rdata_b1 got %h want bbbb0001", rdata_o[1]); end
        tick();
        clear();
    endtask

    task automatic test_backpressure;
        req[0] = 1'b1; add[0] = 32'h0000_0018; gnt_i = 8'h40;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_tests++;
            if (gnt_o[0] !== (c < 4)) begin n_fail++; $display("FAIL bp_gnt c=%0d got %b want %b", c, gnt_o[0], c < 4); end
            if (c >= 4) begin
                n_tests++;
                if (req_o[6] !== 1'b0) begin n_fail++; $display("FAIL bp_req_o c=%0d got %b want 0", c, req_o[6]); end
            end
            tick();
        end
        rvalid_i[6] = 1'b1; rdata_i[6] = 32'h0000_0066;
        @(negedge clk);
        n_tests += 2;
        if (gnt_o[0] !== 1'b0) begin n_fail++; $display("FAIL bp_full_on_pop got %b want 0", gnt_o[0]); end
        if (vld_o !== 4'b0001) begin n_fail++; $display("FAIL bp_vld got %b want 0001", vld_o); end
        tick();
        rvalid_i[6] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (gnt_o[0] !== 1'b1) begin n_fail++; $display("FAIL bp_regrant got %b want 1", gnt_o[0]); end
        tick();
        @(negedge clk);
        n_tests++;
        if (gnt_o[0] !== 1'b0) begin n_fail++; $display("FAIL bp_one_only got %b want 0", gnt_o[0]); end
        tick();
        req = '0; rvalid_i[6] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (vld_o !== 4'b0001) begin n_fail++; $display("FAIL bp_drain c=%0d got %b want 0001", c, vld_o); end
            tick();
        end
        clear();
        @(negedge clk);
        n_tests++;
        if (rready_o !== 8'h00) begin n_fail++; $display("FAIL bp_empty got %h want 00", rready_o); end
        tick();
    endtask

    task automatic test_write_resp;
        req[2] = 1'b1; we[2] = 1'b1; add[2] = 32'h0000_002C;
        wdata[2] = 32'h5555_AAAA; be[2] = 4'b0110; gnt_i = 8'h08;
        @(negedge clk);
        n_tests += 5;
        if (gnt_o !== 4'b0100)             begin n_fail++; $display("FAIL wr_gnt got %b want 0100", gnt_o); end
        if (we_o[3] !== 1'b1)              begin n_fail++; $display("FAIL wr_we_o got %b want 1", we_o[3]); end
        if (wdata_o[3] !== 32'h5555_AAAA)  begin n_fail++; $display("FAIL wr_wdata got %h want 5555aaaa", wdata_o[3]); end
        if (be_o[3] !== 4'b0110)           begin n_fail++; $display("FAIL wr_be got %b want 0110", be_o[3]); end
        if (add_o[3] !== 12'h1)            begin n_fail++; $display("FAIL wr_add got %h want 001", add_o[3]); end
        tick();
        we[2] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (gnt_o !== 4'b0100) begin n_fail++; $display("FAIL wr_rd_gnt got %b want 0100", gnt_o); end
        tick();
        req = '0; gnt_i = '0; rvalid_i[3] = 1'b1; rdata_i[3] = 32'h0;
        @(negedge clk);
        n_tests += 2;
        if (vld_o !== 4'b0100)    begin n_fail++; $display("FAIL wr_ack_on got %b want 0100", vld_o); end
        if (nw_vld_o !== 4'b0000) begin n_fail++; $display("FAIL wr_ack_off got %b want 0000", nw_vld_o); end
        tick();
        rdata_i[3] = 32'h1234_5678;
        @(negedge clk);
        n_tests += 3;
        if (vld_o !== 4'b0100)               begin n_fail++; $display("FAIL wr_rd_vld_on got %b want 0100", vld_o); end
        if (nw_vld_o !== 4'b0100)            begin n_fail++; $display("FAIL wr_rd_vld_off got %b want 0100", nw_vld_o); end
        if (nw_rdata_o[2] !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_rd_data got %h want 12345678", nw_rdata_o[2]); end
        tick();
        clear();
        @(negedge clk);
        n_tests += 2;
        if (rready_o !== 8'h00)    begin n_fail++; $display("FAIL wr_empty_on got %h want 00", rready_o); end
        if (nw_rready_o !== 8'h00) begin n_fail++; $display("FAIL wr_empty_off got %h want 00", nw_rready_o); end
        tick();
    endtask

    task automatic test_reset_midflight;
        logic [AW-1:0] addrs [3];
        addrs[0] = 32'h04; addrs[1] = 32'h08; addrs[2] = 32'h10;
        gnt_i = 8'hFF; req[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            add[0] = addrs[c];
            tick();
        end
        clear();
        rst = 1'b1; rvalid_i = 8'h16;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_tests += 4;
        if (rready_o !== 8'h00) begin n_fail++; $display("FAIL rst_mid_rready got %h want 00", rready_o); end
        if (vld_o !== 4'h0)     begin n_fail++; $display("FAIL rst_mid_vld got %b want 0000", vld_o); end
        if (req_o !== 8'h00)    begin n_fail++; $display("FAIL rst_mid_req_o got %h want 00", req_o); end
        if (gnt_o !== 4'h0)     begin n_fail++; $display("FAIL rst_mid_gnt got %b want 0000", gnt_o); end
        tick();
        rvalid_i = '0; req[3] = 1'b1; add[3] = 32'h0000_001C; gnt_i = 8'h80;
        @(negedge clk);
        n_tests += 2;
        if (gnt_o !== 4'b1000) begin n_fail++; $display("FAIL rst_fresh_gnt got %b want 1000", gnt_o); end
        if (req_o !== 8'h80)   begin n_fail++; $display("FAIL rst_fresh_req got %h want 80", req_o); end
        tick();
        clear();
        rvalid_i[7] = 1'b1; rdata_i[7] = 32'h7777_0007;
        @(negedge clk);
        n_tests += 2;
        if (vld_o !== 4'b1000)            begin n_fail++; $display("FAIL rst_fresh_vld got %b want 1000", vld_o); end
        if (rdata_o[3] !== 32'h7777_0007) begin n_fail++; $display("FAIL rst_fresh_rdata got %h want 77770007", rdata_o[3]); end
        tick();
        clear();
    endtask

    initial begin
        clear();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        test_reset();
        test_single_read();
        test_contention();
        test_out_of_order();
        test_backpressure();
        test_write_resp();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
